truth_table_capture: RTL and testbench
======================================

TRUTH_TABLE_CAPTURE -- requirements
Module: truth_table_capture

Interface
REQ-001 SHALL have parameter EXPECTED, default 8'h44, golden truth table; bit i = expected s for {x,y,z}=i (8'h44 = y&~z).
REQ-002 SHALL have parameter SETTLE_CYCLES, default 2, legal range 1..15, hold cycles per vector when CAPTURE_SETTLE_EN is defined.
REQ-003 SHALL have clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have start  input  1  sweep request, sampled only in IDLE.
REQ-006 SHALL have s  input  1  response of the combinational function under test.
REQ-007 SHALL have x, y, z  output  1 each  stimulus driven to the function under test.
REQ-008 SHALL have busy  output  1  high from the cycle after accepted start until done.
REQ-009 SHALL have done  output  1  single-cycle pulse at sweep end.
REQ-010 SHALL have table_out  output  8  captured truth table, bit i = s sampled for vector i.
REQ-011 SHALL have pass  output  1  table_out == EXPECTED, valid from done onward.
REQ-012 SHALL have first_bad  output  3  lowest vector index whose sample mismatched EXPECTED; 0 when pass.

Function
REQ-013 SHALL implement states IDLE, HOLD, SAMPLE, DONE.
REQ-014 SHALL in IDLE with start=1 load idx=0, drive {x,y,z}=3'b000, clear table_out, pass, first_bad, enter HOLD, assert busy.
REQ-015 SHALL hold each vector N cycles total (HOLD plus SAMPLE), N = SETTLE_CYCLES or 1 per REQ-028/029.
REQ-016 SHALL in SAMPLE register s into table_out[idx] at the clock edge ending that cycle.
REQ-017 SHALL on a mismatch with EXPECTED[idx] update first_bad only if no earlier mismatch recorded (sticky flag).
REQ-018 SHALL after sampling idx<7 increment idx, drive the new {x,y,z}=idx, return to HOLD (or SAMPLE when N=1).
REQ-019 SHALL after sampling idx=7 enter DONE; no wrap to 000 mid-sweep.
REQ-020 SHALL in DONE pulse done=1 for exactly one cycle, deassert busy that cycle, compute pass, return to IDLE.
REQ-021 SHALL hold table_out, pass, first_bad stable in IDLE until the next accepted start.
REQ-022 SHALL hold {x,y,z} at 3'b111 after the sweep until the next start.
REQ-023 SHALL ignore start while busy or in DONE; start high in the DONE cycle is not accepted, start in the following IDLE cycle is.
REQ-024 SHALL make total latency accepted start edge to done pulse = 8*N+1 cycles.

Reset
REQ-025 SHALL on rst_n=0 at a rising edge force state IDLE, idx=0, x=y=z=0, busy=0, done=0, table_out=8'h00, pass=0, first_bad=0.
REQ-026 SHALL abort any sweep in progress on reset with no done pulse; rst_n dominates start in the same cycle.
REQ-027 SHALL accept start on the first edge with rst_n=1 after reset.

Configuration
REQ-028 SHALL with CAPTURE_SETTLE_EN defined hold each vector SETTLE_CYCLES cycles, sampling in the last; latency 8*SETTLE_CYCLES+1.
REQ-029 SHALL without CAPTURE_SETTLE_EN ignore SETTLE_CYCLES, use N=1 (sample the cycle each vector is driven), no settle counter in RTL; latency 9.

Verification
REQ-030 SHALL cover golden: s=y&~z wired back, EXPECTED=8'h44 -> table_out=8'h44, pass=1, first_bad=0, done 9 cycles after start (macro off).
REQ-031 SHALL cover mismatch: s tied 1 -> table_out=8'hFF, pass=0, first_bad=0; s=x&y&z -> table_out=8'h80, first_bad=2.
REQ-032 SHALL cover settle: macro on, SETTLE_CYCLES=3, golden s -> done 25 cycles after start, each vector held 3 cycles, table_out=8'h44.
REQ-033 SHALL cover reset mid-sweep: rst_n=0 at idx=4 -> next cycle busy=0, xyz=000, table_out=8'h00, no done; restart -> pass=1.
REQ-034 SHALL cover start handling: start held high whole sweep -> exactly one done per sweep, second sweep starts the cycle after DONE; start in DONE cycle alone ignored.

Source files
------------

// File: rtl/truth_table_capture.sv
// truth_table_capture: drives {x,y,z} through 0..7, captures s per vector and checks it against EXPECTED.
// Define CAPTURE_SETTLE_EN to hold each vector SETTLE_CYCLES cycles; by default each vector lasts one cycle.
module truth_table_capture #(
    parameter logic [7:0] EXPECTED      = 8'h44,
    parameter int         SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       s,
    output logic       x,
    output logic       y,
    output logic       z,
    output logic       busy,
    output logic       done,
    output logic [7:0] table_out,
    output logic       pass,
    output logic [2:0] first_bad
);
    typedef enum logic [1:0] {IDLE, HOLD, SAMPLE, DONE} state_t;
    state_t     state, next_state;
    logic [2:0] idx;
    logic       bad_seen;
    logic       miss;
    logic       hold_end;
`ifdef CAPTURE_SETTLE_EN
    localparam state_t     FIRST     = (SETTLE_CYCLES > 1) ? HOLD : SAMPLE;
    localparam logic [3:0] LAST_HOLD = 4'(SETTLE_CYCLES - 2);
    logic [3:0] cnt;
    // cnt counts HOLD cycles of the current vector; SAMPLE supplies the final one
    always_ff @(posedge clk) begin
        if (!rst_n || state != HOLD)
            cnt <= 4'd0;
        else
            cnt <= cnt + 4'd1;
    end
    assign hold_end = cnt == LAST_HOLD;
`else
    localparam state_t FIRST = SAMPLE;
    logic unused_settle;
    assign unused_settle = |SETTLE_CYCLES;
    assign hold_end      = 1'b1;
`endif
    assign miss      = s != EXPECTED[idx];
    assign {x, y, z} = idx;
    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= next_state;
    end
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = start ? FIRST : IDLE;
            HOLD:    next_state = hold_end ? SAMPLE : HOLD;
            SAMPLE:  next_state = (idx == 3'd7) ? DONE : FIRST;
            default: next_state = IDLE;
        endcase
    end
    always_comb begin
        busy = state == HOLD || state == SAMPLE;
        done = state == DONE;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx       <= 3'd0;
            table_out <= 8'h00;
            pass      <= 1'b0;
            first_bad <= 3'd0;
            bad_seen  <= 1'b0;
        end else if (state == IDLE && start) begin
            idx       <= 3'd0;
            table_out <= 8'h00;
            pass      <= 1'b0;
            first_bad <= 3'd0;
            bad_seen  <= 1'b0;
        end else if (state == SAMPLE) begin
            table_out[idx] <= s;
            if (miss && !bad_seen) begin
                first_bad <= idx;
                bad_seen  <= 1'b1;
            end
            // idx stays at 7 after the last sample so the stimulus rests at 3'b111
            if (idx == 3'd7)
                pass <= !bad_seen && !miss;
            else
                idx <= idx + 3'd1;
        end
    end
endmodule

// File: tb/tb_truth_table_capture.sv
// tb_truth_table_capture: random and directed sweeps checked every cycle against a sweep-position model.
module tb_truth_table_capture;
    localparam logic [7:0] EXP = 8'h44;
`ifdef CAPTURE_SETTLE_EN
    localparam int N       = 3;
    localparam int LAT_LIT = 25;
`else
    localparam int N       = 1;
    localparam int LAT_LIT = 9;
`endif
    localparam int LAT = 8 * N + 1;

    logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic [7:0] func = 8'h44;
    logic       s, x, y, z, busy, done, pass;
    logic [7:0] table_out;
    logic [2:0] first_bad;
    int         n_cmp = 0, n_bad = 0;

    truth_table_capture #(.EXPECTED(EXP), .SETTLE_CYCLES(3)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .s(s),
        .x(x), .y(y), .z(z), .busy(busy), .done(done),
        .table_out(table_out), .pass(pass), .first_bad(first_bad)
    );

    always #5 clk = ~clk;
    assign s = func[{x, y, z}];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] lowest_bad(input logic [7:0] fv, input int v);
        logic [2:0] r = 3'd0;
        for (int i = v - 1; i >= 0; i--)
            if (fv[i] != EXP[i]) r = 3'(i);
        return r;
    endfunction

    // model: k = cycles since the accepted start (0 when idle); h_* = values held while idle
    int         k = 0;
    logic [7:0] f = 8'h00, h_tab = 8'h00;
    logic       h_pass = 1'b0, live = 1'b0;
    logic [2:0] h_fb = 3'd0, h_xyz = 3'd0;
    always @(posedge clk) begin
        if (!rst_n) begin
            k <= 0; h_tab <= 8'h00; h_pass <= 1'b0; h_fb <= 3'd0; h_xyz <= 3'd0; live <= 1'b1;
        end else if (k == 0) begin
            if (start) begin
                k <= 1; f <= func; h_tab <= 8'h00; h_pass <= 1'b0; h_fb <= 3'd0; h_xyz <= 3'd0;
            end
        end else if (k == LAT) begin
            k <= 0;
        end else begin
            k <= k + 1;
            if (k == LAT - 1) begin
                h_tab <= f; h_pass <= (f == EXP); h_fb <= lowest_bad(f, 8); h_xyz <= 3'd7;
            end
        end
    end

    always @(negedge clk) begin : cmp
        logic [7:0] e_tab;
        logic       e_pass, e_busy, e_done;
        logic [2:0] e_fb, e_xyz;
        int         v;
        if (live) begin
            if (k >= 1 && k <= 8 * N) begin
                v = (k - 1) / N;
                e_busy = 1'b1; e_done = 1'b0; e_xyz = 3'(v); e_pass = 1'b0;
                e_tab = f & 8'((1 << v) - 1);
                e_fb = lowest_bad(f, v);
            end else begin
                e_busy = 1'b0; e_done = (k == LAT); e_xyz = h_xyz;
                e_tab = h_tab; e_pass = h_pass; e_fb = h_fb;
            end
            chk("busy", {7'd0, busy}, {7'd0, e_busy});
            chk("done", {7'd0, done}, {7'd0, e_done});
            chk("xyz", {5'd0, x, y, z}, {5'd0, e_xyz});
            chk("table_out", table_out, e_tab);
            chk("pass", {7'd0, pass}, {7'd0, e_pass});
            chk("first_bad", {5'd0, first_bad}, {5'd0, e_fb});
        end
    end

    task automatic wait_done(output int lat);
        lat = 1;
        @(negedge clk);
        start = 1'b0;
        while (!done && lat < 500) begin
            @(negedge clk);
            lat++;
        end
        if (!done) chk("done_timeout", 8'd0, 8'd1);
    endtask

    task automatic sweep(input logic [7:0] fn, output int lat);
        func = fn;
        start = 1'b1;
        wait_done(lat);
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((busy || done) && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (busy || done) chk("idle_timeout", 8'd0, 8'd1);
    endtask

    initial begin
        int lat, nd, d1, d2, rst_at;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        sweep(8'h44, lat);
        chk("golden_latency", 8'(lat), 8'(LAT_LIT));
        chk("golden_table", table_out, 8'h44);
        chk("golden_pass", {7'd0, pass}, 8'd1);
        chk("golden_first_bad", {5'd0, first_bad}, 8'd0);
        @(negedge clk);
        chk("idle_xyz_held", {5'd0, x, y, z}, 8'd7);
        sweep(8'hFF, lat);
        chk("ones_table", table_out, 8'hFF);
        chk("ones_pass", {7'd0, pass}, 8'd0);
        chk("ones_first_bad", {5'd0, first_bad}, 8'd0);
        @(negedge clk);
        sweep(8'h80, lat);
        chk("and3_table", table_out, 8'h80);
        chk("and3_pass", {7'd0, pass}, 8'd0);
        chk("and3_first_bad", {5'd0, first_bad}, 8'd2);
        @(negedge clk);
        // reset mid-sweep at vector 4, with start held against the reset
        func = 8'h44;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int t = 0; t < 100 && {x, y, z} != 3'd4; t++) @(negedge clk);
        chk("reached_vec4", {5'd0, x, y, z}, 8'd4);
        rst_n = 1'b0;
        start = 1'b1;
        @(negedge clk);
        chk("rst_busy", {7'd0, busy}, 8'd0);
        chk("rst_xyz", {5'd0, x, y, z}, 8'd0);
        chk("rst_table", table_out, 8'h00);
        chk("rst_done", {7'd0, done}, 8'd0);
        rst_n = 1'b1;
        sweep(8'h44, lat);
        chk("restart_pass", {7'd0, pass}, 8'd1);
        chk("restart_latency", 8'(lat), 8'(LAT_LIT));
        @(negedge clk);
        // start held high across two sweeps
        start = 1'b1;
        nd = 0; d1 = 0; d2 = 0;
        for (int i = 1; i <= 2 * LAT + 2; i++) begin
            @(negedge clk);
            if (done) begin
                nd++;
                if (nd == 1) d1 = i; else d2 = i;
            end
        end
        start = 1'b0;
        chk("held_done_count", 8'(nd), 8'd2);
        chk("held_done_gap", 8'(d2 - d1), 8'(LAT + 1));
        wait_idle();
        @(negedge clk);
        // start present only in the DONE cycle
        start = 1'b1;
        wait_done(lat);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("done_start_ignored", {7'd0, busy}, 8'd0);
        // random truth tables, stray starts and occasional resets
        repeat (30) begin
            func = 8'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            start = 1'b1;
            rst_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, LAT)) : -1;
            for (int i = 1; i <= LAT + 2; i++) begin
                @(negedge clk);
                start = ($urandom_range(0, 2) == 0);
                rst_n = (i != rst_at);
            end
            start = 1'b0;
            rst_n = 1'b1;
            @(negedge clk);
            wait_idle();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
